// File: rtl/puf_resp_pkg.sv
// Shared constants and state encoding for the PUF response collector.
// Define PUF_RESP_MAJORITY_EN to enable the 3-sample majority vote per cell.
package puf_resp_pkg;

    localparam int NUM_CELLS = 128;
    localparam int SEL_W     = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

`ifdef PUF_RESP_MAJORITY_EN
    localparam int SAMPLE_CYCLES = 3;
`else
    localparam int SAMPLE_CYCLES = 1;
`endif

endpackage

// File: rtl/puf_maj3.sv
// Combinational 3-input majority vote used by the collector when PUF_RESP_MAJORITY_EN is defined.
module puf_maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/puf_resp_collector.sv
// Walks the PUF mux select over all cells, samples each after a settle delay and hands off a 128-bit response.
// Build option: PUF_RESP_MAJORITY_EN adds a 3-cycle sample window with majority vote per cell.
module puf_resp_collector
    import puf_resp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Start,
    output logic                 o_Busy,
    output logic [SEL_W-1:0]     o_Sel,
    input  logic                 i_Q,
    output logic [NUM_CELLS-1:0] o_Resp,
    output logic                 o_Valid,
    input  logic                 i_Ready
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_CELLS - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] settle_cnt;
    logic       sample_last;
    logic       sample_bit;

`ifdef PUF_RESP_MAJORITY_EN
    localparam logic [1:0] LAST_IDX = 2'(SAMPLE_CYCLES - 1);

    logic [1:0] sample_idx;
    logic       vote0;
    logic       vote1;
    logic       maj_bit;

    // The third sample is voted live, so only the first two need holding registers.
    puf_maj3 u_maj3 (
        .a (vote0),
        .b (vote1),
        .c (i_Q),
        .y (maj_bit)
    );

    assign sample_last = (sample_idx == LAST_IDX);
    assign sample_bit  = maj_bit;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            sample_idx <= 2'd0;
            vote0      <= 1'b0;
            vote1      <= 1'b0;
        end else if (state == SAMPLE) begin
            sample_idx <= sample_last ? 2'd0 : sample_idx + 2'd1;
            if (sample_idx == 2'd0) vote0 <= i_Q;
            if (sample_idx == 2'd1) vote1 <= i_Q;
        end else begin
            sample_idx <= 2'd0;
        end
    end
`else
    assign sample_last = 1'b1;
    assign sample_bit  = i_Q;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_Start) state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE: begin
                if (sample_last) state_next = (o_Sel == SEL_LAST) ? DONE : SETTLE;
            end
            DONE:    if (i_Ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy/valid are registered from the next state so they line up with the state register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            o_Sel      <= '0;
            o_Resp     <= '0;
            o_Valid    <= 1'b0;
            o_Busy     <= 1'b0;
            settle_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            o_Busy  <= (state_next == SETTLE) || (state_next == SAMPLE);
            o_Valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        o_Resp     <= '0;
                        o_Sel      <= '0;
                        settle_cnt <= 8'd0;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 8'd1;
                SAMPLE: begin
                    if (sample_last) begin
                        o_Resp[o_Sel] <= sample_bit;
                        if (o_Sel != SEL_LAST) begin
                            o_Sel      <= o_Sel + 1'b1;
                            settle_cnt <= 8'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Directed bench for puf_resp_collector: default SETTLE_CYCLES=4 instance plus a SETTLE_CYCLES=1 instance.
// Covers the default build (PUF_RESP_MAJORITY_EN undefined).
module tb_puf_resp_collector;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         busy;
    logic [6:0]   sel;
    logic         q;
    logic [127:0] resp;
    logic         valid;
    logic         ready;

    logic         start2;
    logic         busy2;
    logic [6:0]   sel2;
    logic         q2;
    logic [127:0] resp2;
    logic         valid2;
    logic         ready2;

    logic [127:0] data;
    int           n_vec = 0;
    int           n_err = 0;

    localparam logic [127:0] D1 = 128'hA5A5_0F0F_FFFF_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_F0E1_D2C3_B4A5_9687;
    localparam logic [127:0] D3 = 128'hFFFF_0000_AAAA_5555_CAFE_BABE_DEAD_BEEF;

    // Behavioural mux: each instance sees the cell it currently selects.
    assign q  = data[sel];
    assign q2 = data[sel2];

    puf_resp_collector #(.SETTLE_CYCLES(4)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Start (start),
        .o_Busy  (busy),
        .o_Sel   (sel),
        .i_Q     (q),
        .o_Resp  (resp),
        .o_Valid (valid),
        .i_Ready (ready)
    );

    puf_resp_collector #(.SETTLE_CYCLES(1)) dut_fast (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Start (start2),
        .o_Busy  (busy2),
        .o_Sel   (sel2),
        .i_Q     (q2),
        .o_Resp  (resp2),
        .o_Valid (valid2),
        .i_Ready (ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a scan on the SETTLE_CYCLES=4 instance and follows it cycle by cycle until valid.
    task automatic apply_stimulus(input string tag, input logic [127:0] d, input int busy_pulse_at);
        int k;
        int exp_sel;
        int sel_bad;
        int busy_bad;
        k        = 0;
        sel_bad  = 0;
        busy_bad = 0;
        data     = d;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output({tag, "_resp_cleared"}, resp, '0);
        while (valid !== 1'b1 && k < 2000) begin
            exp_sel = (k / 5 > 127) ? 127 : k / 5;
            if (sel !== 7'(exp_sel)) sel_bad++;
            if (busy !== 1'b1) busy_bad++;
            start = (k == busy_pulse_at);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_output({tag, "_valid_edge"}, 128'(k), 128'd640);
        check_output({tag, "_resp"}, resp, d);
        check_output({tag, "_busy_at_done"}, 128'(busy), 128'd0);
        check_output({tag, "_sel_final"}, 128'(sel), 128'd127);
        check_output({tag, "_sel_walk_errors"}, 128'(sel_bad), 128'd0);
        check_output({tag, "_busy_errors"}, 128'(busy_bad), 128'd0);
    endtask

    initial begin
        int hold_bad;
        int k;
        rst_n  = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        start2 = 1'b0;
        ready2 = 1'b0;
        data   = D1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start  = 1'($urandom_range(0, 1));
            ready  = 1'($urandom_range(0, 1));
            start2 = 1'($urandom_range(0, 1));
            ready2 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_output("reset_sel", 128'(sel), 128'd0);
        check_output("reset_resp", resp, '0);
        check_output("reset_valid", 128'(valid), 128'd0);
        check_output("reset_busy", 128'(busy), 128'd0);
        check_output("reset_fast_resp", resp2, '0);
        check_output("reset_fast_busy", 128'(busy2), 128'd0);
        rst_n  = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        start2 = 1'b0;
        ready2 = 1'b0;
        @(negedge clk);
        check_output("idle_busy", 128'(busy), 128'd0);

        apply_stimulus("scan1", D1, -1);

        // Backpressure with a start pulse landing in DONE.
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            @(negedge clk);
            if (valid !== 1'b1 || busy !== 1'b0 || resp !== D1) hold_bad++;
        end
        check_output("hold_errors", 128'(hold_bad), 128'd0);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        check_output("handshake_valid_low", 128'(valid), 128'd0);
        check_output("handshake_start_ignored", 128'(busy), 128'd0);
        check_output("idle_resp_kept", resp, D1);
        check_output("idle_sel_kept", 128'(sel), 128'd127);
        @(negedge clk);
        check_output("no_queued_start", 128'(busy), 128'd0);

        // Start pulse mid-scan must not restart the walk.
        apply_stimulus("scan2", D2, 100);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_output("scan2_handshake", 128'(valid), 128'd0);

        // Abort mid-scan with reset when cell 60 is selected.
        data = D3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (sel !== 7'd60 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_output("reach_sel60", 128'(sel), 128'd60);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort_sel", 128'(sel), 128'd0);
        check_output("abort_resp", resp, '0);
        check_output("abort_busy", 128'(busy), 128'd0);
        check_output("abort_valid", 128'(valid), 128'd0);
        rst_n = 1'b1;
        apply_stimulus("scan3", D3, -1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;

        // SETTLE_CYCLES=1 instance: two cycles per cell.
        data = D2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (valid2 !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_output("fast_valid_edge", 128'(k), 128'd256);
        check_output("fast_resp", resp2, D2);
        check_output("fast_busy_at_done", 128'(busy2), 128'd0);
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        check_output("fast_handshake", 128'(valid2), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
